// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch controller.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSE  = 2'd2,
        ST_ADJUST = 2'd3
    } sw_state_e;

    localparam int unsigned CLK_HZ_DEFAULT = 100_000_000;
    localparam int unsigned TICK4_DIV      = 4;   // tick4 fires CLK_HZ / TICK4_DIV cycles apart
    localparam int unsigned TICK2_PER_T4   = 2;
    localparam int unsigned TICK1_PER_T4   = 4;

    function automatic int unsigned pre_len(input int unsigned clk_hz);
        return clk_hz / TICK4_DIV;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Raw input conditioning: 2-flop synchronizer, stability debouncer and
// optional single-cycle rising-edge pulse.
module btn_debounce #(
    parameter int unsigned DEB_CYCLES = 1_000_000,
    parameter bit          EDGE_EN    = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sig_i,
    output logic level_o,
    output logic rise_c
);

    localparam int unsigned     CNT_W    = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic [1:0]       sync_q;
    logic             stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             accept_c;

    // A new level is taken once it has been seen for DEB_CYCLES consecutive cycles
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        accept_c = (sync_q[1] != stable_q) && (cnt_q == CNT_LAST);
        if (accept_c) begin
            stable_d = sync_q[1];
        end else if (sync_q[1] != stable_q) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q   <= '0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync_q   <= {sync_q[0], sig_i};
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign level_o = stable_q;
    assign rise_c  = EDGE_EN && accept_c && sync_q[1];

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: input conditioning, tick prescaler and IDLE/RUN/PAUSE/ADJUST FSM.
// Define STOPWATCH_LAP_EN to build the lap-hold feature driven by btn_lap.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int unsigned CLK_HZ     = CLK_HZ_DEFAULT,
    parameter int unsigned DEB_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_pause,
    input  logic       btn_rst,
    input  logic       sw_adj,
    input  logic       sw_sel,
    input  logic       btn_lap,
    output logic       cnt_inc,
    output logic       min_inc,
    output logic       cnt_clr,
    output logic       blink,
    output logic       lap_hold,
    output logic [1:0] state
);

    localparam int unsigned      PRE_LEN  = pre_len(CLK_HZ);
    localparam int unsigned      PRE_W    = (PRE_LEN > 1) ? $clog2(PRE_LEN) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRE_LEN - 1);
    localparam int unsigned      SUB_W    = $clog2(TICK1_PER_T4);
    localparam logic [SUB_W-1:0] T2_MASK  = SUB_W'(TICK2_PER_T4 - 1);
    localparam logic [SUB_W-1:0] T1_LAST  = SUB_W'(TICK1_PER_T4 - 1);

    // Asynchronous assertion, synchronous release
    logic [1:0] rst_sync_q;
    logic       rst_int_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync_q <= '0;
        else        rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_int_n = rst_sync_q[1];

    logic pause_rise, clr_rise, adj_lvl, sel_lvl;
    logic pause_lvl_unused, clr_lvl_unused, adj_rise_unused, sel_rise_unused;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES), .EDGE_EN(1'b1)) u_deb_pause (
        .clk(clk), .rst_n(rst_int_n), .sig_i(btn_pause), .level_o(pause_lvl_unused), .rise_c(pause_rise));
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES), .EDGE_EN(1'b1)) u_deb_clr (
        .clk(clk), .rst_n(rst_int_n), .sig_i(btn_rst), .level_o(clr_lvl_unused), .rise_c(clr_rise));
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES), .EDGE_EN(1'b0)) u_deb_adj (
        .clk(clk), .rst_n(rst_int_n), .sig_i(sw_adj), .level_o(adj_lvl), .rise_c(adj_rise_unused));
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES), .EDGE_EN(1'b0)) u_deb_sel (
        .clk(clk), .rst_n(rst_int_n), .sig_i(sw_sel), .level_o(sel_lvl), .rise_c(sel_rise_unused));

    sw_state_e        state_q, state_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic [SUB_W-1:0] sub_q, sub_d;
    logic             cnt_inc_q, cnt_inc_d, min_inc_q, min_inc_d;
    logic             cnt_clr_q, cnt_clr_d, blink_q, blink_d;
    logic             run_pre_c, tick4_c, tick2_c, tick1_c;

`ifdef STOPWATCH_LAP_EN
    logic lap_rise, lap_lvl_unused, lap_q, lap_d;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES), .EDGE_EN(1'b1)) u_deb_lap (
        .clk(clk), .rst_n(rst_int_n), .sig_i(btn_lap), .level_o(lap_lvl_unused), .rise_c(lap_rise));
`else
    logic unused_lap;
    assign unused_lap = btn_lap;
`endif

    always_comb begin
        state_d   = state_q;
        pre_d     = pre_q;
        sub_d     = sub_q;
        cnt_inc_d = 1'b0;
        min_inc_d = 1'b0;
        cnt_clr_d = 1'b0;
        blink_d   = 1'b0;

        // Prescaler only advances while RUN or ADJUST, so PAUSE keeps its phase
        run_pre_c = (state_q == ST_RUN) || (state_q == ST_ADJUST);
        tick4_c   = run_pre_c && (pre_q == PRE_LAST);
        tick2_c   = tick4_c && ((sub_q & T2_MASK) == T2_MASK);
        tick1_c   = tick4_c && (sub_q == T1_LAST);
        if (run_pre_c) begin
            pre_d = tick4_c ? '0 : pre_q + PRE_W'(1);
            if (tick4_c) sub_d = sub_q + SUB_W'(1);
        end

        if (state_q == ST_RUN) begin
            cnt_inc_d = tick1_c;
        end else if ((state_q == ST_ADJUST) && tick2_c) begin
            if (sel_lvl) min_inc_d = 1'b1;
            else         cnt_inc_d = 1'b1;
        end

        // Priority: clear, then adjust switch, then pause
        if (clr_rise) begin
            cnt_clr_d = 1'b1;
            cnt_inc_d = 1'b0;
            min_inc_d = 1'b0;
            pre_d     = '0;
            sub_d     = '0;
            state_d   = adj_lvl ? ST_ADJUST : ST_IDLE;
        end else if (adj_lvl && (state_q != ST_ADJUST)) begin
            state_d = ST_ADJUST;
        end else if (!adj_lvl && (state_q == ST_ADJUST)) begin
            state_d = ST_PAUSE;
        end else if (pause_rise) begin
            case (state_q)
                ST_IDLE, ST_PAUSE: state_d = ST_RUN;
                ST_RUN:            state_d = ST_PAUSE;
                default:           state_d = state_q;
            endcase
        end

        if ((state_q == ST_ADJUST) && (state_d == ST_ADJUST) && !clr_rise) begin
            blink_d = blink_q ^ tick4_c;
        end

`ifdef STOPWATCH_LAP_EN
        lap_d = lap_q;
        if (clr_rise || (state_d != ST_RUN)) lap_d = 1'b0;
        else if (lap_rise && (state_q == ST_RUN)) lap_d = ~lap_q;
`endif
    end

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_q   <= ST_IDLE;
            pre_q     <= '0;
            sub_q     <= '0;
            cnt_inc_q <= 1'b0;
            min_inc_q <= 1'b0;
            cnt_clr_q <= 1'b0;
            blink_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pre_q     <= pre_d;
            sub_q     <= sub_d;
            cnt_inc_q <= cnt_inc_d;
            min_inc_q <= min_inc_d;
            cnt_clr_q <= cnt_clr_d;
            blink_q   <= blink_d;
        end
    end

`ifdef STOPWATCH_LAP_EN
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) lap_q <= 1'b0;
        else            lap_q <= lap_d;
    end
    assign lap_hold = lap_q;
`else
    assign lap_hold = 1'b0;
`endif

    assign cnt_inc = cnt_inc_q;
    assign min_inc = min_inc_q;
    assign cnt_clr = cnt_clr_q;
    assign blink   = blink_q;
    assign state   = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl at CLK_HZ=16, DEB_CYCLES=3.
// Define STOPWATCH_LAP_EN for both DUT and bench to cover the lap-hold build.
module tb_stopwatch_ctrl;

    localparam int unsigned CLK_HZ   = 16;
    localparam int unsigned DEB      = 3;
    localparam int          T1_CYC   = 16;   // cycles per second tick
    localparam int          T2_CYC   = 8;    // cycles per adjust tick
    localparam int          B_PAUSE  = 0;
    localparam int          B_LAP    = 1;
    localparam int          B_CLRPSE = 2;

`ifdef STOPWATCH_LAP_EN
    localparam int EXP_LAP = 1;
`else
    localparam int EXP_LAP = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_pause = 1'b0, btn_rst = 1'b0, sw_adj = 1'b0, sw_sel = 1'b0, btn_lap = 1'b0;
    logic       cnt_inc, min_inc, cnt_clr, blink, lap_hold;
    logic [1:0] state;

    int cyc      = 0;
    int n_checks = 0;
    int n_fail   = 0;
    int phase    = 0;   // prescaler intervals elapsed modulo one second
    int q_cnt[$];
    int q_min[$];
    int q_clr[$];

    stopwatch_ctrl #(.CLK_HZ(CLK_HZ), .DEB_CYCLES(DEB)) dut (
        .clk(clk), .rst_n(rst_n), .btn_pause(btn_pause), .btn_rst(btn_rst),
        .sw_adj(sw_adj), .sw_sel(sw_sel), .btn_lap(btn_lap),
        .cnt_inc(cnt_inc), .min_inc(min_inc), .cnt_clr(cnt_clr),
        .blink(blink), .lap_hold(lap_hold), .state(state)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Pulse monitor: every output pulse must match the head of its expectation queue
    always @(negedge clk) begin
        if (cnt_inc) begin
            if (q_cnt.size() == 0) check_eq("cnt_inc_unexpected", cyc, -1);
            else                   check_eq("cnt_inc_cycle", cyc, q_cnt.pop_front());
        end
        if (min_inc) begin
            if (q_min.size() == 0) check_eq("min_inc_unexpected", cyc, -1);
            else                   check_eq("min_inc_cycle", cyc, q_min.pop_front());
        end
        if (cnt_clr) begin
            if (q_clr.size() == 0) check_eq("cnt_clr_unexpected", cyc, -1);
            else                   check_eq("cnt_clr_cycle", cyc, q_clr.pop_front());
        end
        if (cnt_inc || min_inc || cnt_clr)
            check_eq("pulse_exclusive", int'(cnt_inc) + int'(min_inc) + int'(cnt_clr), 1);
    end

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic press(input int which, input int n);
        case (which)
            B_PAUSE: btn_pause = 1'b1;
            B_LAP:   btn_lap = 1'b1;
            default: begin btn_pause = 1'b1; btn_rst = 1'b1; end
        endcase
        repeat (n) @(negedge clk);
        btn_pause = 1'b0;
        btn_rst   = 1'b0;
        btn_lap   = 1'b0;
    endtask

    // RUN intervals ending at edges s+1..e; cnt_inc follows every 16th one
    task automatic plan_run(input int s, input int e);
        for (int k = s + 1; k <= e; k++) begin
            phase = (phase + 1) % T1_CYC;
            if (phase == 0) q_cnt.push_back(k);
        end
    endtask

    // ADJUST intervals; each 8th one pulses min_inc until sel drops after edge sel_flip
    task automatic plan_adj(input int s, input int e, input int sel_flip);
        for (int k = s + 1; k <= e; k++) begin
            phase = (phase + 1) % T1_CYC;
            if ((phase % T2_CYC) == 0) begin
                if (k - 1 < sel_flip) q_min.push_back(k);
                else                  q_cnt.push_back(k);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int e, r, c, a;
        repeat (3) @(negedge clk);
        check_eq("rst_state", int'(state), 0);
        check_eq("rst_outputs", int'({cnt_inc, min_inc, cnt_clr, blink, lap_hold}), 0);

        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Start, bounce rejection, pause
        e = cyc + 5;
        plan_run(e, e + 45);
        press(B_PAUSE, 4);
        check_eq("idle_before_run", int'(state), 0);
        @(negedge clk);
        check_eq("run_entry", int'(state), 1);
        wait_cyc(e + 20);
        press(B_PAUSE, 2);
        wait_cyc(e + 30);
        check_eq("bounce_ignored", int'(state), 1);
        wait_cyc(e + 40);
        press(B_PAUSE, 4);
        check_eq("run_before_pause", int'(state), 1);
        @(negedge clk);
        check_eq("pause_entry", int'(state), 2);
        wait_cyc(e + 75);
        check_eq("pause_hold", int'(state), 2);

        // Resume keeps prescaler phase; then clear and pause together
        r = cyc + 5;
        c = r + 37;
        plan_run(r, c + 4);
        press(B_PAUSE, 4);
        wait_cyc(r);
        check_eq("resume", int'(state), 1);
        wait_cyc(c);
        q_clr.push_back(c + 5);
        press(B_CLRPSE, 4);
        wait_cyc(c + 4);
        check_eq("run_before_clear", int'(state), 1);
        wait_cyc(c + 5);
        check_eq("clear_idle", int'(state), 0);
        phase = 0;
        wait_cyc(c + 10);
        check_eq("clear_stays_idle", int'(state), 0);

        // Adjust minutes, then seconds, then leave to PAUSE
        wait_cyc(c + 15);
        a = cyc + 6;
        plan_adj(a, a + 50, a + 31);
        sw_adj = 1'b1;
        sw_sel = 1'b1;
        wait_cyc(a - 1);
        check_eq("adj_pending", int'(state), 0);
        wait_cyc(a);
        check_eq("adj_entry", int'(state), 3);
        for (int k = 0; k <= 12; k++) begin
            wait_cyc(a + k);
            check_eq("blink", int'(blink), (k / 4) % 2);
        end
        wait_cyc(a + 26);
        sw_sel = 1'b0;
        wait_cyc(a + 44);
        sw_adj = 1'b0;
        wait_cyc(a + 49);
        check_eq("adj_before_exit", int'(state), 3);
        wait_cyc(a + 50);
        check_eq("adj_exit", int'(state), 2);
        check_eq("blink_off", int'(blink), 0);

        // Reset asserted while a cnt_inc pulse is on the outputs
        wait_cyc(a + 55);
        r = cyc + 5;
        plan_run(r, r + 14);
        press(B_PAUSE, 4);
        wait_cyc(r + 14);
        #2 rst_n = 1'b0;
        #1;
        check_eq("async_rst_state", int'(state), 0);
        check_eq("async_rst_outputs", int'({cnt_inc, min_inc, cnt_clr, blink, lap_hold}), 0);
        phase = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        c = cyc;
        wait_cyc(c + 40);
        check_eq("idle_after_rst", int'(state), 0);

        // Lap press in RUN; pause leaves RUN and drops the hold
        r = cyc + 5;
        plan_run(r, r + 25);
        press(B_PAUSE, 4);
        wait_cyc(r + 3);
        press(B_LAP, 4);
        wait_cyc(r + 7);
        check_eq("lap_before", int'(lap_hold), 0);
        wait_cyc(r + 8);
        check_eq("lap_hold", int'(lap_hold), EXP_LAP);
        check_eq("lap_still_run", int'(state), 1);
        wait_cyc(r + 20);
        press(B_PAUSE, 4);
        wait_cyc(r + 25);
        check_eq("lap_pause_state", int'(state), 2);
        check_eq("lap_released", int'(lap_hold), 0);

        c = cyc;
        wait_cyc(c + 20);
        check_eq("cnt_inc_pending", q_cnt.size(), 0);
        check_eq("min_inc_pending", q_min.size(), 0);
        check_eq("cnt_clr_pending", q_clr.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 Parameter CLK_HZ, default 100_000_000, system clock frequency in Hz; SHALL be a multiple of 4.
REQ-002 Parameter DEB_CYCLES, default 1_000_000, stable cycles before a button change is accepted (10 ms at 100 MHz).
REQ-003 Port clk, input, 1, single system clock, rising edge.
REQ-004 Port rst_n, input, 1, asynchronous active-low reset.
REQ-005 Port btn_pause, input, 1, raw asynchronous pause/run button.
REQ-006 Port btn_rst, input, 1, raw asynchronous clear button.
REQ-007 Port sw_adj, input, 1, raw adjust-mode switch, level.
REQ-008 Port sw_sel, input, 1, raw adjust select switch: 1 = minutes, 0 = seconds.
REQ-009 Port btn_lap, input, 1, raw lap button; used only with STOPWATCH_LAP_EN.
REQ-010 Port cnt_inc, output, 1, one-cycle pulse advancing seconds by one.
REQ-011 Port min_inc, output, 1, one-cycle pulse advancing minutes by one in adjust.
REQ-012 Port cnt_clr, output, 1, one-cycle pulse zeroing the time counter.
REQ-013 Port blink, output, 1, display blank strobe for the adjusted field.
REQ-014 Port lap_hold, output, 1, high = display frozen at lap value.
REQ-015 Port state, output, 2, current FSM state encoding.

Function
REQ-016 All inputs SHALL pass a 2-flop synchronizer; buttons additionally debounced, then rising-edge detected into one-cycle pulses; switches debounced as levels.
REQ-017 Prescaler SHALL emit tick4 once every CLK_HZ/4 cycles; tick2 on every 2nd tick4, tick1 on every 4th tick4.
REQ-018 States: IDLE=0, RUN=1, PAUSE=2, ADJUST=3.
REQ-019 IDLE: pause pulse -> RUN; no increments.
REQ-020 RUN: cnt_inc pulses on the cycle after each tick1; pause pulse -> PAUSE.
REQ-021 PAUSE: no increments, prescaler held; pause pulse -> RUN, resuming prescaler phase without loss.
REQ-022 Any state with debounced sw_adj=1 -> ADJUST; ADJUST with sw_adj=0 -> PAUSE.
REQ-023 ADJUST: on each tick2, pulse min_inc if sw_sel=1 else cnt_inc; pause pulses ignored.
REQ-024 blink SHALL toggle on each tick4 in ADJUST and be 0 in all other states.
REQ-025 Clear pulse in any state SHALL produce cnt_clr for exactly one cycle, reset prescaler to 0 and go IDLE, or stay ADJUST if sw_adj=1.
REQ-026 Simultaneous events priority: clear > adjust > pause; losing events are dropped, not queued.
REQ-027 cnt_inc and min_inc SHALL never assert in the same cycle, nor with cnt_clr.

Reset
REQ-028 On rst_n low: state=IDLE, prescaler=0, synchronizers/debouncers=0, all outputs 0, asynchronously; deassertion sampled synchronously through a 2-flop reset synchronizer.

Configuration
REQ-029 With STOPWATCH_LAP_EN defined, a lap pulse in RUN SHALL toggle lap_hold; counting continues; lap_hold cleared by clear pulse, leaving RUN, or reset.
REQ-030 Without STOPWATCH_LAP_EN, btn_lap is ignored and lap_hold is tied 0; no lap logic synthesized.

Structure
REQ-031 Package stopwatch_pkg SHALL hold the state enum, CLK_HZ default and tick divisor constants.
REQ-032 Sub-module btn_debounce (sync + debounce + optional edge pulse) SHALL be instantiated once per input.

Verification (CLK_HZ=16, DEB_CYCLES=3)
REQ-033 Reset then pause press -> state=1 after 5 cycles; cnt_inc every 16 cycles thereafter.
REQ-034 Pause held 2 cycles (bounce) -> no state change; held 4 cycles -> RUN<->PAUSE toggle once.
REQ-035 sw_adj=1, sw_sel=1 -> state=3, min_inc every 8 cycles, blink toggles every 4 cycles, cnt_inc=0.
REQ-036 Clear and pause pressed same cycle in RUN -> single cnt_clr pulse, state=0.
REQ-037 rst_n low mid-RUN during tick -> all outputs 0 immediately, no cnt_inc after release.
REQ-038 LAP_EN build: lap press in RUN -> lap_hold=1, cnt_inc continues; pause press -> lap_hold=0.
